// File: rtl/pcint_input_conditioner_pkg.sv
// Shared register map and bit positions for the pin-change interrupt input stage.
package pcint_input_conditioner_pkg;

  // Register byte offsets from BASE_ADDR.
  localparam logic [31:0] PCINT_PCICR  = 32'h0000_0000;
  localparam logic [31:0] PCINT_PCIFR  = 32'h0000_0004;
  localparam logic [31:0] PCINT_PCMSK0 = 32'h0000_0008;
  localparam logic [31:0] PCINT_PCMSK2 = 32'h0000_000C;

  localparam int unsigned PCIE0 = 0;
  localparam int unsigned PCIE2 = 2;
  localparam int unsigned PCIF0 = 0;
  localparam int unsigned PCIF2 = 2;

  // Only the Port B and Port D enable/flag bits exist.
  localparam logic [7:0] PORT_BITS_MASK = 8'h05;

  typedef enum logic [1:0] {
    RegPcicr,
    RegPcifr,
    RegPcmsk0,
    RegPcmsk2
  } reg_sel_e;

endpackage

// File: rtl/pcint_input_conditioner_pin_synchronizer.sv
// Multi-flop level synchroniser for asynchronous pad inputs; no filtering.
module pin_synchronizer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pcint_input_conditioner.sv
// Pad synchroniser plus ATmega-style pin-change interrupt registers for Ports B and D.
module pcint_input_conditioner #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0100,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic [7:0]  pad_in_b,
  input  logic [7:0]  pad_in_d,
  output logic [7:0]  pin_sync_b,
  output logic [7:0]  pin_sync_d,
  output logic        irq_pcint0,
  output logic        irq_pcint2
);
  import pcint_input_conditioner_pkg::*;

  localparam logic [2:0] ArmDone = 3'(SYNC_STAGES + 1);

  logic [7:0] prev_b, prev_d;
  logic [7:0] pcicr, pcifr, pcmsk0, pcmsk2;
  logic [7:0] pcifr_d;
  logic [7:0] change_b, change_d;
  logic [7:0] reg_val;
  logic [2:0] arm_cnt;
  logic       armed;
  logic       sel;
  logic       wr_en;
  reg_sel_e   reg_idx;
  logic       unused_bus_bits;

  assign unused_bus_bits = ^{mem_wdata[31:8], mem_wstrb[3:1]};

  pin_synchronizer #(
    .WIDTH  (8),
    .STAGES (SYNC_STAGES)
  ) u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_in_b),
    .q     (pin_sync_b)
  );

  pin_synchronizer #(
    .WIDTH  (8),
    .STAGES (SYNC_STAGES)
  ) u_sync_d (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pad_in_d),
    .q     (pin_sync_d)
  );

  always_comb begin
    sel     = 1'b1;
    reg_idx = RegPcicr;
    case (mem_addr)
      BASE_ADDR + PCINT_PCICR:  reg_idx = RegPcicr;
      BASE_ADDR + PCINT_PCIFR:  reg_idx = RegPcifr;
      BASE_ADDR + PCINT_PCMSK0: reg_idx = RegPcmsk0;
      BASE_ADDR + PCINT_PCMSK2: reg_idx = RegPcmsk2;
      default:                  sel = 1'b0;
    endcase
  end

  always_comb begin
    reg_val = 8'h00;
    unique case (reg_idx)
      RegPcicr:  reg_val = pcicr;
      RegPcifr:  reg_val = pcifr;
      RegPcmsk0: reg_val = pcmsk0;
      RegPcmsk2: reg_val = pcmsk2;
      default:   reg_val = 8'h00;
    endcase
  end

  assign mem_rdata = sel ? {24'h0, reg_val} : 32'h0;
  assign wr_en     = mem_valid & sel & mem_wstrb[0];

  // Until the synchroniser chain has flushed its reset zeros, level changes are not real edges.
  assign armed    = (arm_cnt == ArmDone);
  assign change_b = armed ? ((pin_sync_b ^ prev_b) & pcmsk0) : 8'h00;
  assign change_d = armed ? ((pin_sync_d ^ prev_d) & pcmsk2) : 8'h00;

  always_comb begin
    pcifr_d = pcifr;
    if (wr_en && (reg_idx == RegPcifr)) begin
      pcifr_d = pcifr & ~(mem_wdata[7:0] & PORT_BITS_MASK);
    end
    // A new change beats a simultaneous clear.
    if (|change_b) pcifr_d[PCIF0] = 1'b1;
    if (|change_d) pcifr_d[PCIF2] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_b    <= 8'h00;
      prev_d    <= 8'h00;
      pcicr     <= 8'h00;
      pcifr     <= 8'h00;
      pcmsk0    <= 8'h00;
      pcmsk2    <= 8'h00;
      arm_cnt   <= 3'd0;
      mem_ready <= 1'b0;
    end else begin
      prev_b    <= pin_sync_b;
      prev_d    <= pin_sync_d;
      pcifr     <= pcifr_d;
      mem_ready <= mem_valid & sel;
      if (arm_cnt != ArmDone) arm_cnt <= arm_cnt + 3'd1;
      if (wr_en && (reg_idx == RegPcicr))  pcicr  <= mem_wdata[7:0] & PORT_BITS_MASK;
      if (wr_en && (reg_idx == RegPcmsk0)) pcmsk0 <= mem_wdata[7:0];
      if (wr_en && (reg_idx == RegPcmsk2)) pcmsk2 <= mem_wdata[7:0];
    end
  end

  assign irq_pcint0 = pcifr[PCIF0] & pcicr[PCIE0];
  assign irq_pcint2 = pcifr[PCIF2] & pcicr[PCIE2];

endmodule

// File: tb/tb_pcint_input_conditioner.sv
// Directed bench for pcint_input_conditioner against an edge-counting reference model.
module tb_pcint_input_conditioner;

  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam int          S    = 2;
  localparam logic [31:0] A_PCICR  = BASE + 32'h0;
  localparam logic [31:0] A_PCIFR  = BASE + 32'h4;
  localparam logic [31:0] A_PCMSK0 = BASE + 32'h8;
  localparam logic [31:0] A_PCMSK2 = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [7:0]  pad_in_b, pad_in_d;
  logic [7:0]  pin_sync_b, pin_sync_d;
  logic        irq_pcint0, irq_pcint2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pcint_input_conditioner #(
    .BASE_ADDR   (BASE),
    .SYNC_STAGES (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pad_in_b   (pad_in_b),
    .pad_in_d   (pad_in_d),
    .pin_sync_b (pin_sync_b),
    .pin_sync_d (pin_sync_d),
    .irq_pcint0 (irq_pcint0),
    .irq_pcint2 (irq_pcint2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: pad levels after edge j are the samples taken S-1 edges earlier;
  // flags need S+1 edges since reset before any level difference counts.
  int         edges;
  logic [7:0] samp_b[$];
  logic [7:0] samp_d[$];
  logic [7:0] m_pcicr, m_pcifr, m_msk0, m_msk2;
  logic       m_ready;

  function automatic logic [7:0] lvl_b(input int j);
    if (j < S) return 8'h00;
    return samp_b[j-S];
  endfunction

  function automatic logic [7:0] lvl_d(input int j);
    if (j < S) return 8'h00;
    return samp_d[j-S];
  endfunction

  function automatic logic hit(input logic [31:0] a);
    return (a == A_PCICR) || (a == A_PCIFR) || (a == A_PCMSK0) || (a == A_PCMSK2);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a == A_PCICR)  return {24'h0, m_pcicr};
    if (a == A_PCIFR)  return {24'h0, m_pcifr};
    if (a == A_PCMSK0) return {24'h0, m_msk0};
    if (a == A_PCMSK2) return {24'h0, m_msk2};
    return 32'h0;
  endfunction

  initial begin
    logic [7:0] setf;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edges = 0;
        samp_b.delete();
        samp_d.delete();
        m_pcicr = 8'h00; m_pcifr = 8'h00; m_msk0 = 8'h00; m_msk2 = 8'h00;
        m_ready = 1'b0;
      end else begin
        setf = 8'h00;
        if (edges >= S + 1) begin
          if (((lvl_b(edges) ^ lvl_b(edges - 1)) & m_msk0) != 8'h00) setf[0] = 1'b1;
          if (((lvl_d(edges) ^ lvl_d(edges - 1)) & m_msk2) != 8'h00) setf[2] = 1'b1;
        end
        if (mem_valid && hit(mem_addr) && mem_wstrb[0]) begin
          if (mem_addr == A_PCICR)  m_pcicr = mem_wdata[7:0] & 8'h05;
          if (mem_addr == A_PCIFR)  m_pcifr = m_pcifr & ~(mem_wdata[7:0] & 8'h05);
          if (mem_addr == A_PCMSK0) m_msk0  = mem_wdata[7:0];
          if (mem_addr == A_PCMSK2) m_msk2  = mem_wdata[7:0];
        end
        m_pcifr = m_pcifr | setf;
        m_ready = mem_valid && hit(mem_addr);
        samp_b.push_back(pad_in_b);
        samp_d.push_back(pad_in_d);
        edges++;
      end
    end
  end

  always @(negedge clk) begin
    check("pin_sync_b", {24'h0, pin_sync_b}, {24'h0, lvl_b(edges)});
    check("pin_sync_d", {24'h0, pin_sync_d}, {24'h0, lvl_d(edges)});
    check("irq_pcint0", {31'h0, irq_pcint0}, {31'h0, m_pcifr[0] & m_pcicr[0]});
    check("irq_pcint2", {31'h0, irq_pcint2}, {31'h0, m_pcifr[2] & m_pcicr[2]});
    check("mem_ready", {31'h0, mem_ready}, {31'h0, m_ready});
    check("mem_rdata", mem_rdata, exp_rdata(mem_addr));
  end

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data,
                           input logic [3:0] strb);
    @(posedge clk); #2;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = {24'h0, data}; mem_wstrb = strb;
    @(posedge clk); #2;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [7:0] exp, input string name);
    @(posedge clk); #2;
    mem_valid = 1'b1; mem_addr = addr; mem_wstrb = 4'h0;
    @(negedge clk);
    check(name, mem_rdata, {24'h0, exp});
    @(posedge clk); #2;
    mem_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    pad_in_b = 8'hFF; pad_in_d = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset pin_sync_b", {24'h0, pin_sync_b}, 32'h0);
    #1 rst_n = 1'b1;

    // High pads at reset with mask written during arming: no flag.
    bus_write(A_PCMSK0, 8'hFF, 4'h1);
    @(negedge clk);
    check("sync after S clocks", {24'h0, pin_sync_b}, 32'h0000_00FF);
    idle(4);
    bus_read(A_PCIFR, 8'h00, "no flag at arming");

    // Set up Port B: clear residue, mask bit 2, enable PCIE0.
    bus_write(A_PCMSK0, 8'h00, 4'h1);
    pad_in_b = 8'h00;
    idle(5);
    bus_write(A_PCMSK0, 8'h04, 4'h1);
    bus_write(A_PCICR, 8'h01, 4'h1);
    pad_in_b = 8'h08;
    idle(5);
    bus_read(A_PCIFR, 8'h00, "unmasked pin no flag");

    // Bit 2 rises: sampled at edge N, flag visible after edge N+S.
    pad_in_b = 8'h0C;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("irq0 before N+S", {31'h0, irq_pcint0}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("irq0 at N+S", {31'h0, irq_pcint0}, 32'h1);
    idle(1);
    bus_read(A_PCIFR, 8'h01, "PCIFR after edge");

    bus_write(A_PCIFR, 8'h00, 4'h1);
    bus_read(A_PCIFR, 8'h01, "write 0 keeps flag");
    bus_write(A_PCIFR, 8'h01, 4'h1);
    @(negedge clk);
    check("w1c clears irq0", {31'h0, irq_pcint0}, 32'h0);

    // Falling edge sets the flag, then a clear collides with a new rising edge.
    pad_in_b = 8'h08;
    idle(5);
    check("falling edge flag", {31'h0, irq_pcint0}, 32'h1);
    pad_in_b = 8'h0C;
    @(posedge clk);
    @(posedge clk); #2;
    mem_valid = 1'b1; mem_addr = A_PCIFR; mem_wdata = 32'h1; mem_wstrb = 4'h1;
    @(posedge clk); #2;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    check("set beats clear", {31'h0, irq_pcint0}, 32'h1);

    // Port D flag with its interrupt disabled, then enabled.
    bus_write(A_PCIFR, 8'h05, 4'h1);
    bus_write(A_PCICR, 8'h00, 4'h1);
    bus_write(A_PCMSK2, 8'h80, 4'h1);
    pad_in_d = 8'h80;
    idle(1);
    pad_in_d = 8'h00;
    idle(5);
    bus_read(A_PCIFR, 8'h04, "PCIFR port D");
    check("irq2 disabled", {31'h0, irq_pcint2}, 32'h0);
    bus_write(A_PCICR, 8'h04, 4'h1);
    @(negedge clk);
    check("irq2 after enable", {31'h0, irq_pcint2}, 32'h1);

    // Bus corner cases.
    bus_read(BASE + 32'h10, 8'h00, "unmapped rdata");
    @(negedge clk);
    check("unmapped no ready", {31'h0, mem_ready}, 32'h0);
    bus_write(A_PCMSK2, 8'hFF, 4'b0010);
    @(negedge clk);
    check("upper strobe ready", {31'h0, mem_ready}, 32'h1);
    bus_read(A_PCMSK2, 8'h80, "upper strobe ignored");
    @(posedge clk); #2;
    mem_valid = 1'b1; mem_addr = A_PCICR; mem_wstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) check("back-to-back ready", {31'h0, mem_ready}, 32'h1);
      @(posedge clk);
    end
    #2 mem_valid = 1'b0;

    // Asynchronous reset with flags pending and pads moving.
    bus_write(A_PCICR, 8'h05, 4'h1);
    pad_in_b = 8'h08;
    idle(5);
    check("irq0 before reset", {31'h0, irq_pcint0}, 32'h1);
    pad_in_b = 8'hFF; pad_in_d = 8'h80;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async rst pin_sync_b", {24'h0, pin_sync_b}, 32'h0);
    check("async rst pin_sync_d", {24'h0, pin_sync_d}, 32'h0);
    check("async rst irqs", {30'h0, irq_pcint2, irq_pcint0}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    bus_write(A_PCMSK0, 8'hFF, 4'h1);
    bus_write(A_PCICR, 8'h05, 4'h1);
    idle(4);
    bus_read(A_PCIFR, 8'h00, "no flag after re-arm");
    pad_in_b = 8'hFE;
    idle(5);
    bus_read(A_PCIFR, 8'h01, "real edge after re-arm");
    check("irq0 after re-arm", {31'h0, irq_pcint0}, 32'h1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
